// File: rtl/apb2cbus_ctrl_if.sv
// rtl/apb2cbus_ctrl_if.sv - APB4 and CBUS signal bundle for the apb2cbus bridge
//
// Purpose : groups the APB slave-side and CBUS master-side signals of the
//           bridge so that they can be passed as a single port.
// Modports: slave  - bridge view (APB inputs, CBUS request outputs)
//           master - environment view (APB master plus CBUS peripheral)
interface apb2cbus_ctrl_if #(
  parameter int ADDRW = 8,
  parameter int DATAW = 32
);
  logic [ADDRW-1:0]   apb_paddr;
  logic               apb_psel;
  logic               apb_penable;
  logic               apb_pwrite;
  logic [DATAW-1:0]   apb_pwdata;
  logic [DATAW/8-1:0] apb_pstrb;
  logic               apb_pready;
  logic               apb_pslverr;
  logic [DATAW-1:0]   apb_prdata;

  logic               cbus_s_req;
  logic               cbus_s_cmd;
  logic [ADDRW-1:0]   cbus_s_address;
  logic [DATAW/8-1:0] cbus_s_byten;
  logic [9:0]         cbus_s_bytecnt;
  logic               cbus_s_first;
  logic               cbus_s_last;
  logic [DATAW-1:0]   cbus_s_wdata;
  logic [DATAW-1:0]   cbus_s_rdatap;
  logic               cbus_s_rresp;
  logic               cbus_s_waccept;

  modport slave (
    input  apb_paddr, apb_psel, apb_penable, apb_pwrite, apb_pwdata, apb_pstrb,
    output apb_pready, apb_pslverr, apb_prdata,
    output cbus_s_req, cbus_s_cmd, cbus_s_address, cbus_s_byten, cbus_s_bytecnt,
    output cbus_s_first, cbus_s_last, cbus_s_wdata,
    input  cbus_s_rdatap, cbus_s_rresp, cbus_s_waccept
  );

  modport master (
    output apb_paddr, apb_psel, apb_penable, apb_pwrite, apb_pwdata, apb_pstrb,
    input  apb_pready, apb_pslverr, apb_prdata,
    input  cbus_s_req, cbus_s_cmd, cbus_s_address, cbus_s_byten, cbus_s_bytecnt,
    input  cbus_s_first, cbus_s_last, cbus_s_wdata,
    output cbus_s_rdatap, cbus_s_rresp, cbus_s_waccept
  );
endinterface

// File: rtl/apb2cbus_ctrl.sv
// rtl/apb2cbus_ctrl.sv - parametrised APB4-to-CBUS single-beat slave bridge
//
// Purpose : turns each APB access into one registered single-beat CBUS
//           request, with response timeout, clock-disable guard and a
//           saturating error counter.
// Ports   : cbus_s_clk      bridge clock
//           cbus_s_rst_n    asynchronous active-low reset
//           cbus_s_clk_dis  async peripheral clock-disable (synchronised here)
//           bus             apb2cbus_ctrl_if.slave (APB slave + CBUS master)
//           err_cnt         saturating count of error completions

module sync_2ff_arst (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);
  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;
endmodule

module apb2cbus_ctrl #(
  parameter int ADDRW = 8,
  parameter int DATAW = 32,
  parameter int TOUT  = 255,
  parameter int TOUTW = 8
) (
  input  logic                  cbus_s_clk,
  input  logic                  cbus_s_rst_n,
  input  logic                  cbus_s_clk_dis,
  apb2cbus_ctrl_if.slave        bus,
  output logic [7:0]            err_cnt
);
  localparam int BW = DATAW / 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Last timer value of the response window; only meaningful when TOUT != 0.
  localparam logic [TOUTW-1:0] TOUT_M1 = TOUTW'(TOUT - 1);

  logic [1:0]       r_state;
  logic             r_req;
  logic             r_cmd;
  logic [ADDRW-1:0] r_addr;
  logic [BW-1:0]    r_byten;
  logic [DATAW-1:0] r_wdata;
  logic [DATAW-1:0] r_prdata;
  logic             r_pready;
  logic             r_pslverr;
  logic [TOUTW-1:0] r_timer;
  logic [7:0]       r_err_cnt;

  logic w_dis_s;
  logic w_access;
  logic w_resp;
  logic w_tout;
  logic w_err_ev;

  sync_2ff_arst u_dis_sync (
    .i_clk   (cbus_s_clk),
    .i_rst_n (cbus_s_rst_n),
    .i_d     (cbus_s_clk_dis),
    .o_q     (w_dis_s)
  );

  assign w_access = bus.apb_psel & bus.apb_penable;
  // Response qualifier follows the direction of the held request.
  assign w_resp   = r_cmd ? bus.cbus_s_rresp : bus.cbus_s_waccept;
  assign w_tout   = (TOUT != 0) && (r_timer == TOUT_M1);

  // Error completions: refused while the peripheral clock is off, or timed out.
  // A response in the timeout cycle takes precedence, so it is not an error.
  assign w_err_ev = ((r_state == S_IDLE) & w_access & w_dis_s) |
                    ((r_state == S_REQ) & ~w_resp & w_tout);

  always_ff @(posedge cbus_s_clk or negedge cbus_s_rst_n) begin
    if (!cbus_s_rst_n) begin
      r_state   <= S_IDLE;
      r_req     <= 1'b0;
      r_cmd     <= 1'b0;
      r_addr    <= '0;
      r_byten   <= '0;
      r_wdata   <= '0;
      r_prdata  <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_timer   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_access) begin
            if (w_dis_s) begin
              r_state   <= S_RESP;
              r_pready  <= 1'b1;
              r_pslverr <= 1'b1;
            end else begin
              r_state <= S_REQ;
              r_req   <= 1'b1;
              r_timer <= '0;
              r_addr  <= bus.apb_paddr;
              r_wdata <= bus.apb_pwdata;
              r_cmd   <= ~bus.apb_pwrite;
              r_byten <= bus.apb_pwrite ? bus.apb_pstrb : {BW{1'b1}};
            end
          end
        end
        S_REQ: begin
          r_timer <= r_timer + 1'b1;
          if (w_resp) begin
            r_state   <= S_RESP;
            r_req     <= 1'b0;
            r_pready  <= 1'b1;
            r_pslverr <= 1'b0;
            if (r_cmd) begin
              r_prdata <= bus.cbus_s_rdatap;
            end
          end else if (w_tout) begin
            r_state   <= S_RESP;
            r_req     <= 1'b0;
            r_pready  <= 1'b1;
            r_pslverr <= 1'b1;
            r_prdata  <= '0;
          end
        end
        S_RESP: begin
          r_state   <= S_IDLE;
          r_pready  <= 1'b0;
          r_pslverr <= 1'b0;
        end
        default: begin
          r_state   <= S_IDLE;
          r_req     <= 1'b0;
          r_pready  <= 1'b0;
          r_pslverr <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge cbus_s_clk or negedge cbus_s_rst_n) begin
    if (!cbus_s_rst_n) begin
      r_err_cnt <= 8'd0;
    end else if (w_err_ev && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign bus.apb_pready     = r_pready;
  assign bus.apb_pslverr    = r_pslverr;
  assign bus.apb_prdata     = r_prdata;
  assign bus.cbus_s_req     = r_req;
  assign bus.cbus_s_cmd     = r_cmd;
  assign bus.cbus_s_address = r_addr;
  assign bus.cbus_s_byten   = r_byten;
  assign bus.cbus_s_wdata   = r_wdata;
  assign bus.cbus_s_bytecnt = 10'(BW);
  assign bus.cbus_s_first   = 1'b1;
  assign bus.cbus_s_last    = 1'b1;
  assign err_cnt            = r_err_cnt;
endmodule
